// File: rtl/pipe_stall_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central stall/flush controller.
// The pipeline side (master) raises requests; the controller (slave) answers with stall/flush.
interface pipe_stall_ctrl_if #(
  parameter int CNT_W  = 6,
  parameter int PERF_W = 32
);
  logic              stallreq_id;
  logic              stallreq_ex;
  logic [CNT_W-1:0]  ex_mc_len;
  logic              excp_req;
  logic [31:0]       excp_vector;
  logic [5:0]        stall;
  logic              flush;
  logic [31:0]       new_pc;
  logic              mc_last;
  logic              mc_abort;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output stallreq_id, stallreq_ex, ex_mc_len, excp_req, excp_vector,
    input  stall, flush, new_pc, mc_last, mc_abort, stall_cycles
  );

  modport slave (
    input  stallreq_id, stallreq_ex, ex_mc_len, excp_req, excp_vector,
    output stall, flush, new_pc, mc_last, mc_abort, stall_cycles
  );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage core: arbitrates exception flush,
// EX multi-cycle ops and ID load-use bubbles, and counts stalled cycles.
module pipe_stall_ctrl #(
  parameter int CNT_W        = 6,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stall_ctrl_if.slave bus
);

  localparam int FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
  localparam logic [5:0]        STALL_MC  = 6'b001111;
  localparam logic [5:0]        STALL_LU  = 6'b000111;
  localparam logic [PERF_W-1:0] PERF_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MC_BUSY = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [FCNT_W-1:0] r_fcnt;
  logic [FCNT_W-1:0] w_fcnt_next;
  logic [31:0]       r_pc_q;
  logic [31:0]       w_pc_next;
  logic [PERF_W-1:0] r_stall_cycles;

  logic [5:0]        w_stall;
  logic              w_flush;
  logic              w_mc_last;
  logic              w_mc_abort;
  logic [31:0]       w_new_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_fcnt         <= '0;
      r_pc_q         <= '0;
      r_stall_cycles <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_fcnt  <= w_fcnt_next;
      r_pc_q  <= w_pc_next;
      if (w_stall[0] && (r_stall_cycles != PERF_MAX))
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_fcnt_next  = r_fcnt;
    w_pc_next    = r_pc_q;
    w_stall      = '0;
    w_flush      = 1'b0;
    w_mc_last    = 1'b0;
    w_mc_abort   = 1'b0;
    w_new_pc     = bus.excp_req ? bus.excp_vector : r_pc_q;

    // Exceptions pre-empt everything, including an in-flight multi-cycle op.
    if (bus.excp_req) begin
      w_flush    = 1'b1;
      w_pc_next  = bus.excp_vector;
      w_cnt_next = '0;
      w_mc_abort = (r_state == S_MC_BUSY);
      if (FLUSH_CYCLES > 1) begin
        w_state_next = S_FLUSH;
        w_fcnt_next  = FCNT_LOAD;
      end else begin
        w_state_next = S_IDLE;
      end
    end else begin
      unique case (r_state)
        S_FLUSH: begin
          w_flush = 1'b1;
          if (r_fcnt == '0)
            w_state_next = S_IDLE;
          else
            w_fcnt_next = r_fcnt - FCNT_W'(1);
        end
        S_MC_BUSY: begin
          if (r_cnt != '0) begin
            w_stall    = STALL_MC;
            w_cnt_next = r_cnt - CNT_W'(1);
          end else begin
            w_mc_last    = 1'b1;
            w_state_next = S_IDLE;
          end
        end
        default: begin
          // Countdown holds len-2: the request cycle and the mc_last cycle are not counted.
          if (bus.stallreq_ex) begin
            if (bus.ex_mc_len >= CNT_W'(2)) begin
              w_stall      = STALL_MC;
              w_cnt_next   = bus.ex_mc_len - CNT_W'(2);
              w_state_next = S_MC_BUSY;
            end else begin
              w_mc_last = 1'b1;
            end
          end else if (bus.stallreq_id) begin
            w_stall = STALL_LU;
          end
        end
      endcase
    end
  end

  // Reset forces every output low regardless of the inputs.
  assign bus.stall        = rst ? w_stall    : '0;
  assign bus.flush        = rst ? w_flush    : 1'b0;
  assign bus.mc_last      = rst ? w_mc_last  : 1'b0;
  assign bus.mc_abort     = rst ? w_mc_abort : 1'b0;
  assign bus.new_pc       = rst ? w_new_pc   : '0;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a cycle-level reference model pushes expected
// outputs per transaction; an independent monitor pops and compares them.
module tb_pipe_stall_ctrl;
  localparam int CNT_W        = 6;
  localparam int FLUSH_CYCLES = 2;
  localparam int PERF_W       = 4;
  localparam int PERF_MAX     = (1 << PERF_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if #(.CNT_W(CNT_W), .PERF_W(PERF_W)) bus ();

  pipe_stall_ctrl #(
    .CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH_CYCLES), .PERF_W(PERF_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [5:0]        stall;
    logic              flush;
    logic [31:0]       new_pc;
    logic              mc_last;
    logic              mc_abort;
    logic [PERF_W-1:0] stall_cycles;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model: remaining op cycles, remaining flush cycles, last vector, stall count.
  int          m_op_left    = 0;
  int          m_flush_left = 0;
  int          m_cnt        = 0;
  logic [31:0] m_pc         = '0;

  task automatic drive(input logic rst_v, input logic id, input logic ex,
                       input int len, input logic xr, input logic [31:0] vec,
                       input string tag);
    obs_t e;
    @(negedge clk);
    rst             = rst_v;
    bus.stallreq_id = id;
    bus.stallreq_ex = ex;
    bus.ex_mc_len   = CNT_W'(len);
    bus.excp_req    = xr;
    bus.excp_vector = vec;
    e = '0;
    if (!rst_v) begin
      m_op_left = 0; m_flush_left = 0; m_cnt = 0; m_pc = '0;
    end else begin
      e.new_pc = xr ? vec : m_pc;
      if (xr) begin
        e.flush      = 1'b1;
        e.mc_abort   = (m_op_left > 0);
        m_pc         = vec;
        m_flush_left = FLUSH_CYCLES - 1;
        m_op_left    = 0;
      end else if (m_flush_left > 0) begin
        e.flush = 1'b1;
        m_flush_left--;
      end else if (m_op_left > 0) begin
        if (m_op_left > 1) e.stall = 6'b001111;
        else               e.mc_last = 1'b1;
        m_op_left--;
      end else if (ex) begin
        if (len >= 2) begin
          e.stall   = 6'b001111;
          m_op_left = len - 1;
        end else begin
          e.mc_last = 1'b1;
        end
      end else if (id) begin
        e.stall = 6'b000111;
      end
      e.stall_cycles = PERF_W'(m_cnt);
      if (e.stall[0] && m_cnt < PERF_MAX) m_cnt++;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  initial begin : monitor
    obs_t  e;
    obs_t  a;
    string t;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a.stall        = bus.stall;
        a.flush        = bus.flush;
        a.new_pc       = bus.new_pc;
        a.mc_last      = bus.mc_last;
        a.mc_abort     = bus.mc_abort;
        a.stall_cycles = bus.stall_cycles;
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s @%0t: got stall=%b flush=%b new_pc=%h last=%b abort=%b cyc=%0d, expected stall=%b flush=%b new_pc=%h last=%b abort=%b cyc=%0d",
                   t, $time, a.stall, a.flush, a.new_pc, a.mc_last, a.mc_abort, a.stall_cycles,
                   e.stall, e.flush, e.new_pc, e.mc_last, e.mc_abort, e.stall_cycles);
        end else begin
          $display("[TB] %s ok stall=%b flush=%b new_pc=%h last=%b abort=%b cyc=%0d",
                   t, a.stall, a.flush, a.new_pc, a.mc_last, a.mc_abort, a.stall_cycles);
        end
      end
    end
  end

  initial begin : stimulus
    bus.stallreq_id = 1'b0;
    bus.stallreq_ex = 1'b0;
    bus.ex_mc_len   = '0;
    bus.excp_req    = 1'b0;
    bus.excp_vector = '0;

    // Reset state and asynchronous reset mid-cycle
    repeat (2) drive(0, 1, 0, 0, 0, 32'h0, "reset_hold");
    drive(1, 1, 0, 0, 0, 32'h0, "lu_after_reset");
    drive(1, 1, 0, 0, 0, 32'h0, "lu_repeat");
    drive(1, 0, 0, 0, 0, 32'h0, "idle");
    drive(0, 1, 0, 0, 0, 32'h0, "async_reset");
    drive(1, 0, 0, 0, 0, 32'h0, "idle");

    // Multi-cycle op of length 5, requests ignored while busy
    drive(1, 0, 1, 5, 0, 32'h0, "mc5_start");
    repeat (4) drive(1, 1, 1, 3, 0, 32'h0, "mc5_busy");
    drive(1, 0, 0, 0, 0, 32'h0, "idle");

    // Single-cycle ops
    drive(1, 0, 1, 1, 0, 32'h0, "short_len1");
    drive(1, 1, 1, 0, 0, 32'h0, "short_len0");
    drive(1, 0, 0, 0, 0, 32'h0, "idle");

    // Exception aborts an 8-cycle op on its 3rd cycle
    drive(1, 0, 1, 8, 0, 32'h0, "mc8_start");
    drive(1, 0, 0, 0, 0, 32'h0, "mc8_busy");
    drive(1, 0, 0, 0, 1, 32'hBFC00380, "abort");
    drive(1, 1, 1, 4, 0, 32'h0, "flush_hold");
    repeat (2) drive(1, 0, 0, 0, 0, 32'h0, "after_flush");

    // Priority among all three requesters
    drive(1, 1, 1, 3, 1, 32'h12345678, "prio_excp");
    drive(1, 0, 0, 0, 0, 32'h0, "prio_flush_hold");
    drive(1, 1, 1, 3, 0, 32'h0, "prio_mc");
    repeat (2) drive(1, 0, 0, 0, 0, 32'h0, "prio_mc_busy");

    // Counter saturation
    drive(0, 0, 0, 0, 0, 32'h0, "sat_reset");
    repeat (20) drive(1, 1, 0, 0, 0, 32'h0, "sat_stall");
    drive(1, 0, 0, 0, 0, 32'h0, "sat_hold");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, 10)),
            ($urandom_range(0, 15) == 0), $urandom, "rand");
    end

    @(negedge clk);
    #5;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central pipeline controller for the 5-stage core. Drives the per-stage stall vector and the flush that sequence every pipeline register, including the ID/EX register.
- Arbitrates three requesters: load-use bubble from ID, multi-cycle ops from EX, exception flush from MEM. Owns the EX multi-cycle countdown and a saturating stall-cycle performance counter.

Parameters:
- CNT_W, 6, width of the multi-cycle length input and the countdown register.
- FLUSH_CYCLES, 2, number of consecutive cycles flush is held per exception (≥1).
- PERF_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- stallreq_id  in  1  load-use hazard detected in ID.
- stallreq_ex  in  1  EX holds a multi-cycle op (div/madd); sampled only in IDLE.
- ex_mc_len  in  CNT_W  total EX cycles for that op; valid with stallreq_ex.
- excp_req  in  1  exception/eret taken in MEM.
- excp_vector  in  32  target PC for excp_req.
- stall  out  6  bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).
- flush  out  1  clear all pipeline registers to NOP.
- new_pc  out  32  redirect PC while flush=1.
- mc_last  out  1  final cycle of an EX op; EX writes its result.
- mc_abort  out  1  in-flight multi-cycle op killed by an exception.
- stall_cycles  out  PERF_W  count of cycles with stall[0]=1; saturates at all-ones.

Behaviour:
- States: IDLE, MC_BUSY, FLUSH. The state, countdown cnt, latched pc_q, flush counter fcnt and stall_cycles are registers.
- stall, flush, mc_last and mc_abort are combinational from state and inputs, giving zero-cycle response.
- new_pc = excp_vector in the excp_req cycle, otherwise pc_q.
- Reset (rst=0, async): state=IDLE, cnt=0, fcnt=0, pc_q=0, stall_cycles=0. All outputs are forced to 0 while rst=0. Reset mid-MC_BUSY or mid-FLUSH abandons the operation with no mc_abort pulse.
- Priority in any state: excp_req > multi-cycle > load-use.
- excp_req=1, any state:
  - flush=1, stall=0, pc_q<=excp_vector.
  - If FLUSH_CYCLES>1, next state FLUSH with fcnt<=FLUSH_CYCLES-2; otherwise next state IDLE.
  - If state was MC_BUSY, mc_abort=1 this cycle and mc_last=0.
- FLUSH state:
  - flush=1, stall=0, new_pc=pc_q.
  - fcnt==0 → IDLE, otherwise fcnt--.
  - A new excp_req re-latches the vector and restarts the count.
  - stallreq_id and stallreq_ex are ignored.
- IDLE, stallreq_ex=1, ex_mc_len≥2: stall=6'b001111, cnt<=ex_mc_len-2, next state MC_BUSY.
- IDLE, stallreq_ex=1, ex_mc_len∈{0,1}: single-cycle op. No stall, mc_last=1, stay in IDLE.
- MC_BUSY:
  - cnt≠0: stall=6'b001111, cnt--.
  - cnt==0: stall=0, mc_last=1, next state IDLE.
  - Net effect: stall is high for exactly ex_mc_len-1 cycles and mc_last is high on cycle ex_mc_len.
  - stallreq_ex and stallreq_id are ignored while busy; EX re-raises stallreq_ex for the next op.
- IDLE, stallreq_id=1 only: stall=6'b000111, so ID/EX inserts a bubble. One cycle per request, no state change.
- IDLE with both stallreq_ex and stallreq_id: the EX rule applies (stall=001111 also freezes ID).
- stall_cycles increments every cycle with stall[0]=1 (not during flush) and holds at 2^PERF_W-1.
- stall is never nonzero while flush=1. stall[5] is always 0.

Test Plan:
- Reset: rst=0 asynchronously mid-cycle with stallreq_id=1 → stall=0 and stall_cycles=0 immediately. After release, IDLE and stall=6'b000111 on the next stallreq_id.
- Multi-cycle op: stallreq_ex=1, ex_mc_len=5 → stall=001111 for 4 consecutive cycles, mc_last=1 on cycle 5, stall=0 on cycle 5. stall_cycles increments by 4.
- Short op: ex_mc_len=1, then ex_mc_len=0 → no stall, mc_last=1 in the request cycle, state stays IDLE.
- Abort: excp_req=1, excp_vector=32'hBFC00380 on the 3rd cycle of an ex_mc_len=8 op → mc_abort=1, flush=1, stall=0 that cycle. Flush holds 2 cycles total with new_pc=32'hBFC00380, then IDLE with no mc_last.
- Priority: stallreq_id, stallreq_ex (len 3) and excp_req together → flush only. With excp_req=0 → stall=001111.
- Saturation: PERF_W=4, drive 20 stall cycles → stall_cycles stops at 4'hF.
